// File: rtl/mac_seq_pkg.sv
// Shared defaults and state encoding for the MAC sequencer.
package mac_seq_pkg;

  localparam int N_COEF = 8;
  localparam int A_W    = 16;
  localparam int B_W    = 16;
  localparam int C_W    = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mac_coef_rf.sv
// Coefficient register file: reset-preset to i+1, written only while idle,
// read combinationally so the current MAC step sees the indexed entry at once.
module mac_coef_rf #(
  parameter int N_COEF = mac_seq_pkg::N_COEF,
  parameter int A_W    = mac_seq_pkg::A_W,
  parameter int IDX_W  = $clog2(N_COEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic             idle,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [A_W-1:0]   wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [A_W-1:0]   rd_data
);

  logic [A_W-1:0]    coef_reg [N_COEF];
  logic [N_COEF-1:0] we;

  // Per-entry write decode; writes outside IDLE are simply dropped.
  genvar gi;
  generate
    for (gi = 0; gi < N_COEF; gi++) begin : g_we
      assign we[gi] = wr_en && idle && (wr_addr == IDX_W'(gi));
    end
  endgenerate

  // Storage update: reset reloads the ramp 1..N_COEF, otherwise decoded writes.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_COEF; i++) begin
      if (!rst_n) begin
        coef_reg[i] <= A_W'(i + 1);
      end else if (we[i]) begin
        coef_reg[i] <= wr_data;
      end
    end
  end

  assign rd_data = coef_reg[rd_idx];

endmodule

// File: rtl/mac_seq_ctrl.sv
// Clocked multiply-accumulate sequencer: one coefficient*operand step per
// clock, start/ready request handshake and valid/ready result handshake.
module mac_seq_ctrl #(
  parameter int N_COEF = mac_seq_pkg::N_COEF,
  parameter int A_W    = mac_seq_pkg::A_W,
  parameter int B_W    = mac_seq_pkg::B_W,
  parameter int C_W    = mac_seq_pkg::C_W,
  parameter int IDX_W  = $clog2(N_COEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [A_W-1:0]   wr_data,
  input  logic             start,
  output logic             start_ready,
  input  logic [B_W-1:0]   b_in,
  output logic             busy,
  output logic [C_W-1:0]   result,
  output logic             result_valid,
  input  logic             result_ready
);

  import mac_seq_pkg::*;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [C_W-1:0]     acc_reg, acc_next;
  logic [C_W-1:0]     result_reg, result_next;
  logic [B_W-1:0]     b_reg, b_next;
  logic [A_W-1:0]     coef;
  logic [A_W+B_W-1:0] prod;
  logic [C_W-1:0]     prod_c;
  logic [C_W-1:0]     acc_sum;
  logic               idle;
  logic               last_step;

  assign idle = (state_reg == S_IDLE);

  mac_coef_rf #(
    .N_COEF (N_COEF),
    .A_W    (A_W),
    .IDX_W  (IDX_W)
  ) u_coef_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .idle    (idle),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_idx  (idx_reg),
    .rd_data (coef)
  );

  // Full-width unsigned product, then resized to the accumulator width;
  // the accumulate wraps modulo 2^C_W with no saturation.
  assign prod      = {{B_W{1'b0}}, coef} * {{A_W{1'b0}}, b_reg};
  assign prod_c    = C_W'(prod);
  assign acc_sum   = acc_reg + prod_c;
  assign last_step = (idx_reg == IDX_W'(N_COEF - 1));

  // Next-state, datapath and result capture.
  always_comb begin
    state_next  = state_reg;
    idx_next    = idx_reg;
    acc_next    = acc_reg;
    b_next      = b_reg;
    result_next = result_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          b_next     = b_in;
          acc_next   = '0;
          idx_next   = '0;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        acc_next = acc_sum;
        if (last_step) begin
          result_next = acc_sum;
          state_next  = S_DONE;
        end else begin
          idx_next = idx_reg + 1'b1;
        end
      end
      S_DONE: begin
        if (result_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State and datapath registers; reset also aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      idx_reg    <= '0;
      acc_reg    <= '0;
      b_reg      <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      idx_reg    <= idx_next;
      acc_reg    <= acc_next;
      b_reg      <= b_next;
      result_reg <= result_next;
    end
  end

  assign start_ready  = idle;
  assign busy         = (state_reg == S_RUN) || (state_reg == S_DONE);
  assign result_valid = (state_reg == S_DONE);
  assign result       = result_reg;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: expected sums are computed from a
// coefficient model when an operation is accepted and compared on handshake.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        start;
  logic        start_ready;
  logic [15:0] b_in;
  logic        busy;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] sb [$];
  logic [15:0] model_coef [8];

  mac_seq_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .start_ready  (start_ready),
    .b_in         (b_in),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .result_ready (result_ready)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_coef[i] = 16'(i + 1);
  endtask

  function automatic logic [31:0] model_sum(input logic [15:0] b);
    logic [31:0] acc = 32'd0;
    for (int i = 0; i < 8; i++) acc = acc + 32'(model_coef[i]) * 32'(b);
    return acc;
  endfunction

  // Write one coefficient while idle; the model follows.
  task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    model_coef[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  // Request an operation, optionally with a same-cycle coefficient write.
  task automatic start_op(input logic [15:0] b, input bit do_wr,
                          input logic [2:0] a, input logic [15:0] d);
    int n = 0;
    while (start_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_val("start_ready_timeout", 32'd0, 32'd1);
    start = 1'b1;
    b_in  = b;
    if (do_wr) begin
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      model_coef[a] = d;
    end
    sb.push_back(model_sum(b));
    tick();
    start = 1'b0;
    wr_en = 1'b0;
    b_in  = 16'($urandom);
  endtask

  // Wait until every expected result has been consumed, then let the
  // handshake edge complete.
  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check_val("drain_timeout", 32'(sb.size()), 32'd0);
    tick();
  endtask

  // Result monitor: a handshake happens at the next rising edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && result_valid === 1'b1 && result_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [31:0] exp;
        exp = sb.pop_front();
        check_val("result", result, exp);
        $display("txn result=%h expected=%h", result, exp);
      end
    end
  end

  initial begin
    int cnt;
    logic [31:0] held;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; b_in = '0; result_ready = 1'b1;
    model_reset();
    tick(); tick();
    rst_n = 1'b1;
    check_val("rst_result", result, 32'd0);
    check_val("rst_valid", 32'(result_valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_start_ready", 32'(start_ready), 32'd1);

    // Default coefficients, b=2: latency and handshake timing.
    start_op(16'd2, 1'b0, 3'd0, 16'd0);
    check_val("run_busy", 32'(busy), 32'd1);
    check_val("run_start_ready", 32'(start_ready), 32'd0);
    cnt = 0;
    while (result_valid !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    // valid is seen by the consumer at the edge after it appears: T+9
    check_val("valid_edge_after_accept", 32'(cnt + 1), 32'd9);
    check_val("done_start_ready", 32'(start_ready), 32'd0);
    tick();
    check_val("post_hs_start_ready", 32'(start_ready), 32'd1);
    check_val("post_hs_valid", 32'(result_valid), 32'd0);
    check_val("post_hs_result_kept", result, 32'd72);
    check_val("post_hs_sb_empty", 32'(sb.size()), 32'd0);

    // Default coefficients, full-scale operand.
    start_op(16'hFFFF, 1'b0, 3'd0, 16'd0);
    wait_drain();

    // Backpressure: valid and result held 20 cycles, start ignored.
    result_ready = 1'b0;
    start_op(16'd3, 1'b0, 3'd0, 16'd0);
    cnt = 0;
    while (result_valid !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    held = result;
    check_val("bp_result", held, 32'd108);
    for (int i = 0; i < 20; i++) begin
      start = i[0];
      b_in  = 16'd11;
      tick();
      check_val("bp_valid_held", 32'(result_valid), 32'd1);
      check_val("bp_result_held", result, held);
      check_val("bp_start_ready", 32'(start_ready), 32'd0);
    end
    start = 1'b0;
    result_ready = 1'b1;
    wait_drain();
    check_val("bp_no_extra_op", 32'(busy), 32'd0);

    // Write and start during RUN are dropped.
    start_op(16'd7, 1'b0, 3'd0, 16'd0);
    tick(); tick();
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'd100;
    start = 1'b1; b_in = 16'd5;
    tick();
    wr_en = 1'b0; start = 1'b0;
    wait_drain();
    repeat (3) tick();
    check_val("run_start_dropped", 32'(busy), 32'd0);
    start_op(16'd1, 1'b0, 3'd0, 16'd0);
    wait_drain();

    // Coefficient write in the accept cycle is used by that operation.
    start_op(16'd1, 1'b1, 3'd2, 16'd10);
    wait_drain();

    // All coefficients at maximum: modulo-2^32 wrap.
    for (int i = 0; i < 8; i++) write_coef(3'(i), 16'hFFFF);
    start_op(16'hFFFF, 1'b0, 3'd0, 16'd0);
    wait_drain();
    check_val("wrap_result_kept", result, 32'hFFF00008);

    // Reset during the 4th RUN step aborts the operation.
    start_op(16'd9, 1'b0, 3'd0, 16'd0);
    tick(); tick(); tick();
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    tick();
    rst_n = 1'b1;
    check_val("abort_valid", 32'(result_valid), 32'd0);
    check_val("abort_busy", 32'(busy), 32'd0);
    check_val("abort_start_ready", 32'(start_ready), 32'd1);
    check_val("abort_result", result, 32'd0);
    repeat (12) tick();
    check_val("abort_no_valid", 32'(result_valid), 32'd0);
    start_op(16'd1, 1'b0, 3'd0, 16'd0);
    wait_drain();
    check_val("abort_reload_result", result, 32'd36);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer for the coefficient-by-operand multiply-accumulate datapath: C = sum over i of A[i]*B, with 8 x 16-bit coefficients, a 16-bit operand and a 32-bit accumulator.
- Replaces the delay-driven loop with a clocked controller:
  - writable coefficient store
  - start/ready request handshake
  - one MAC step per clock
  - valid/ready result handshake with backpressure.
- Sits between a host/config port and downstream result consumers.

Parameters:
- N_COEF, 8, number of coefficients (MAC steps per operation); power of two, at least 2.
- A_W, 16, coefficient width.
- B_W, 16, operand width.
- C_W, 32, accumulator/result width.
- IDX_W, 3, index width, equal to log2(N_COEF).

Ports:
- clk  in  1  single clock; every register updates on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  coefficient write strobe.
- wr_addr  in  IDX_W  coefficient index.
- wr_data  in  A_W  coefficient value.
- start  in  1  operation request.
- start_ready  out  1  high while IDLE; a request is accepted when start and start_ready are both high.
- b_in  in  B_W  operand, sampled on acceptance.
- busy  out  1  high in RUN and DONE.
- result  out  C_W  accumulated sum.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.

Behaviour:
- Reset (rst_n low at a clock edge):
  - state goes to IDLE.
  - idx = 0, acc = 0, b_reg = 0.
  - result = 0, result_valid = 0, busy = 0, start_ready = 1.
  - Coefficient i reloads to i+1, giving 1..8 for the default parameters.
- Reset applied mid-operation (RUN or DONE) aborts the operation. No result_valid is produced for it.
- States:
  - IDLE: start_ready = 1. When start is accepted: latch b_in into b_reg, clear acc and idx, go to RUN.
  - RUN: each cycle, acc <= acc + coef[idx] * b_reg, then idx <= idx + 1. The step where idx == N_COEF-1 transitions to DONE.
  - DONE: result_valid = 1 and result holds the final acc. When result_ready is high, go to IDLE and drop result_valid on the next edge.
- Latency: start is accepted at edge T. The RUN steps occur at edges T+1..T+N_COEF. result_valid is high from T+N_COEF+1. Throughput is one operation per N_COEF+2 cycles with result_ready tied high.
- Arithmetic:
  - Each product is a full A_W+B_W bit unsigned product, zero-extended or truncated to C_W.
  - Accumulation wraps modulo 2^C_W. There is no saturation and no overflow flag.
- start while not IDLE: ignored. No queueing.
- b_in changes after acceptance: no effect.
- Coefficient writes:
  - Accepted only in IDLE, including the same cycle a start is accepted. That write is visible to the operation being started.
  - Writes in RUN or DONE are dropped, and the coefficient store is unchanged.
- result stays stable while result_valid is high and result_ready is low, for any number of cycles.
- result keeps its last value after handshake until the next operation completes. result_valid is the only qualifier.
- idx never wraps mid-operation. It is cleared at each accept.

Decomposition:
- Package mac_seq_pkg holds:
  - state encoding localparams: S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2.
  - default widths N_COEF, A_W, B_W, C_W.
- One sub-module, mac_coef_rf:
  - N_COEF x A_W register file.
  - Synchronous write gated by wr_en and an idle signal.
  - Combinational read on idx.
  - Reset loads the values i+1.
- The FSM, accumulator and handshake stay in mac_seq_ctrl.

Test Plan:
- After reset with default coefficients, start with b_in = 2 and result_ready high -> result_valid rises 9 cycles after accept, result = 72. start_ready returns high one cycle after the handshake.
- Default coefficients, b_in = 16'hFFFF -> result = 32'h0023FFDC.
- Write all 8 coefficients to 16'hFFFF, then start with b_in = 16'hFFFF -> result = 32'hFFF00008, which checks modulo-2^32 wrap.
- result_ready held low for 20 cycles after valid -> result_valid and result held constant, start pulses ignored, start_ready = 0. Raising result_ready completes the handshake.
- During RUN: write wr_addr = 0, wr_data = 100, and pulse start with b_in = 5 -> both ignored. The current result is unchanged and a later read-back operation still uses coefficient 0 = 1.
- Assert rst_n low for 1 cycle at step 4 of a RUN -> result_valid is never raised for that operation, all outputs are at reset values, and coefficients are back to 1..8. The next operation with b_in = 1 gives 36.
